// File: rtl/memtest_pkg.sv
// Shared types and helpers for the memtest BRAM self-test controller.
package memtest_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int MAX_DATA_W = 64;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} bist_state_t;

  // Callers zero-extend into and truncate out of MAX_DATA_W.
  function automatic logic [MAX_DATA_W-1:0] bist_exp(input logic [MAX_DATA_W-1:0] seed,
                                                     input logic [MAX_DATA_W-1:0] addr);
    return seed ^ addr;
  endfunction
endpackage

// File: rtl/memtest_rd_tracker.sv
// RD_LAT-deep {valid, addr} delay line that lines up read tags with port-A data.
module memtest_rd_tracker import memtest_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_vld,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              tag_vld,
  output logic [ADDR_W-1:0] tag_addr
);
  logic [RD_LAT-1:0]             vld_q, vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    vld_d[0]  = push_vld;
    addr_d[0] = push_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  assign tag_vld  = vld_q[RD_LAT-1];
  assign tag_addr = addr_q[RD_LAT-1];
endmodule

// File: rtl/memtest_bist_ctrl.sv
// BIST sequencer: optional seed-pattern fill through port B, then full read/compare via port A.
module memtest_bist_ctrl import memtest_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DATA_W/8,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] q_a,
  output logic [BE_W-1:0]   we_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] din_b
);
  localparam int              DEPTH      = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST       = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] DRAIN_LAST = (ADDR_W+1)'(RD_LAT-1);

  bist_state_t       state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] din_b_q, din_b_d;
  logic [DATA_W-1:0] wr_data;
  logic              tag_vld;
  logic [ADDR_W-1:0] tag_addr;

  function automatic logic [DATA_W-1:0] exp_at(input logic [DATA_W-1:0] s,
                                               input logic [ADDR_W-1:0] a);
    return DATA_W'(bist_exp(MAX_DATA_W'(s), MAX_DATA_W'(a)));
  endfunction

  memtest_rd_tracker #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (state_q == READ),
    .push_addr(ptr_q[ADDR_W-1:0]),
    .tag_vld  (tag_vld),
    .tag_addr (tag_addr)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    seed_d   = seed_q;
    err_d    = err_q;
    first_d  = first_q;
    done_d   = done_q;
    pass_d   = pass_q;
    addr_b_d = addr_b_q;
    din_b_d  = din_b_q;
    wr_data  = exp_at(seed_q, ptr_q[ADDR_W-1:0]);

    // err_q==0 doubles as "no mismatch seen yet": it only returns to 0 on a new start.
    if (tag_vld && (q_a != exp_at(seed_q, tag_addr))) begin
      if (err_q == '0) first_d = tag_addr;
      if (err_q != '1) err_d = err_q + 1'b1;
    end

    case (state_q)
      IDLE: if (start) begin
        state_d = mode ? READ : WRITE;
        ptr_d   = '0;
        seed_d  = seed;
        err_d   = '0;
        first_d = '0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
      WRITE: begin
        addr_b_d = ptr_q[ADDR_W-1:0];
        din_b_d  = wr_data;
        if (ptr_q == LAST) begin
          ptr_d   = '0;
          state_d = READ;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      READ: begin
        if (ptr_q == LAST) begin
          ptr_d   = '0;
          state_d = DRAIN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (ptr_q == DRAIN_LAST) state_d = DONE;
        else                     ptr_d   = ptr_q + 1'b1;
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      seed_q   <= '0;
      err_q    <= '0;
      first_q  <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      addr_b_q <= '0;
      din_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      seed_q   <= seed_d;
      err_q    <= err_d;
      first_q  <= first_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      addr_b_q <= addr_b_d;
      din_b_q  <= din_b_d;
    end
  end

  // Write port is driven straight from state so reset kills we_b without waiting for an edge.
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign addr_a         = (state_q == READ)  ? ptr_q[ADDR_W-1:0] : '0;
  assign we_b           = (state_q == WRITE) ? '1 : '0;
  assign addr_b         = (state_q == WRITE) ? ptr_q[ADDR_W-1:0] : addr_b_q;
  assign din_b          = (state_q == WRITE) ? wr_data : din_b_q;
endmodule
